// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry, tag types and the commit slot record
// used between the ROB commit stage and the committed architectural map.
package core_pkg;

  localparam int NUM_AREG = 32;
  localparam int NUM_PREG = 128;
  localparam int PREG_W   = 7;
  localparam int AREG_W   = 5;
  localparam int COMMIT_W = 2;
  localparam int CNT_W    = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef struct packed {
    logic  valid;
    logic  has_rd;
    areg_t areg;
    preg_t preg;
  } commit_slot_t;

  // A slot only touches the map when it retires with a real destination; x0 stays hardwired.
  function automatic logic slot_effective(input commit_slot_t s);
    return s.valid & s.has_rd & (s.areg != AREG_W'(0));
  endfunction

endpackage

// File: rtl/arch_commit_map_wrap_counter.sv
// Free-running counter that adds a variable increment each cycle and wraps modulo 2^W.
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count, natural wrap from the fixed width
  always_comb begin
    count_d = count_q + inc;
  end

  // count register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/arch_commit_map.sv
// Committed (retirement) register alias table: records areg->preg per retiring slot, returns
// superseded tags to the free list and presents the committed map for flush recovery.
module arch_commit_map
  import core_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COMMIT_W-1:0]          commit_valid,
  input  logic [COMMIT_W-1:0]          commit_has_rd,
  input  logic [COMMIT_W*AREG_W-1:0]   commit_areg,
  input  logic [COMMIT_W*PREG_W-1:0]   commit_preg,
  input  logic                         flush,
  output logic [COMMIT_W-1:0]          freed_valid,
  output logic [COMMIT_W*PREG_W-1:0]   freed_preg,
  output logic                         restore_valid,
  output logic [NUM_AREG*PREG_W-1:0]   restore_map,
  input  logic [AREG_W-1:0]            dbg_areg,
  output logic [PREG_W-1:0]            dbg_preg,
  output logic [CNT_W-1:0]             retired_count,
  output logic [15:0]                  flush_count
);

  commit_slot_t        slot_s [COMMIT_W];
  preg_t               map_q  [NUM_AREG];
  preg_t               map_d  [NUM_AREG];
  logic [COMMIT_W-1:0] freed_valid_q;
  logic [COMMIT_W-1:0] freed_valid_d;
  preg_t               freed_preg_q [COMMIT_W];
  preg_t               freed_preg_d [COMMIT_W];
  logic                restore_valid_q;
  logic [CNT_W-1:0]    retire_inc_s;
  logic [15:0]         flush_inc_s;

  // unpack the flat commit buses into per-slot records
  always_comb begin
    for (int i = 0; i < COMMIT_W; i++) begin
      slot_s[i].valid  = commit_valid[i];
      slot_s[i].has_rd = commit_has_rd[i];
      slot_s[i].areg   = commit_areg[i*AREG_W +: AREG_W];
      slot_s[i].preg   = commit_preg[i*PREG_W +: PREG_W];
    end
  end

  // Slots are applied oldest first on a working copy, so a younger slot that hits the same
  // areg frees the tag just written by the older one and wins the final mapping.
  always_comb begin
    map_d         = map_q;
    freed_valid_d = '0;
    freed_preg_d  = freed_preg_q;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (slot_effective(slot_s[i])) begin
        freed_valid_d[i]          = 1'b1;
        freed_preg_d[i]           = map_d[slot_s[i].areg];
        map_d[slot_s[i].areg]     = slot_s[i].preg;
      end else begin
        freed_valid_d[i]          = 1'b0;
      end
    end
  end

  // map, free-list return and restore pulse registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int a = 0; a < NUM_AREG; a++) begin
        map_q[a] <= PREG_W'(a);
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        freed_preg_q[i] <= '0;
      end
      freed_valid_q   <= '0;
      restore_valid_q <= 1'b0;
    end else begin
      map_q           <= map_d;
      freed_preg_q    <= freed_preg_d;
      freed_valid_q   <= freed_valid_d;
      restore_valid_q <= flush;
    end
  end

  // retired count advances by the number of valid slots, regardless of destination
  always_comb begin
    retire_inc_s = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      retire_inc_s = retire_inc_s + CNT_W'(commit_valid[i]);
    end
    flush_inc_s = 16'(flush);
  end

  wrap_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_inc_s),
    .count (retired_count)
  );

  wrap_counter #(.W(16)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_s),
    .count (flush_count)
  );

  // restore_map mirrors the array continuously; consumers qualify with restore_valid
  always_comb begin
    for (int a = 0; a < NUM_AREG; a++) begin
      restore_map[a*PREG_W +: PREG_W] = map_q[a];
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      freed_preg[i*PREG_W +: PREG_W] = freed_preg_q[i];
    end
  end

  assign freed_valid   = freed_valid_q;
  assign restore_valid = restore_valid_q;
  assign dbg_preg      = map_q[dbg_areg];

endmodule

// File: tb/tb_arch_commit_map.sv
// Randomized scoreboard bench for arch_commit_map against an array-based reference model.
module tb_arch_commit_map;
  import core_pkg::*;

  localparam int MAPW = NUM_AREG * PREG_W;

  logic                        clk;
  logic                        reset;
  logic [1:0]                  commit_valid;
  logic [1:0]                  commit_has_rd;
  logic [9:0]                  commit_areg;
  logic [13:0]                 commit_preg;
  logic                        flush;
  logic [1:0]                  freed_valid;
  logic [13:0]                 freed_preg;
  logic                        restore_valid;
  logic [MAPW-1:0]             restore_map;
  logic [4:0]                  dbg_areg;
  logic [6:0]                  dbg_preg;
  logic [31:0]                 retired_count;
  logic [15:0]                 flush_count;

  arch_commit_map dut (
    .clk           (clk),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_has_rd (commit_has_rd),
    .commit_areg   (commit_areg),
    .commit_preg   (commit_preg),
    .flush         (flush),
    .freed_valid   (freed_valid),
    .freed_preg    (freed_preg),
    .restore_valid (restore_valid),
    .restore_map   (restore_map),
    .dbg_areg      (dbg_areg),
    .dbg_preg      (dbg_preg),
    .retired_count (retired_count),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      fv;
    preg_t           fp0;
    preg_t           fp1;
    logic            rv;
    logic [31:0]     ret;
    logic [15:0]     fl;
    logic [MAPW-1:0] map;
  } rec_t;

  typedef struct {
    logic [15:0]     fl;
    logic [MAPW-1:0] map;
  } rst_rec_t;

  rec_t     cq [$];
  preg_t    fq0 [$];
  preg_t    fq1 [$];
  rst_rec_t rq [$];

  preg_t       mmap [NUM_AREG];
  preg_t       m_fp [2];
  logic [31:0] m_ret;
  logic [15:0] m_fl;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [MAPW-1:0] pack_map();
    logic [MAPW-1:0] m;
    for (int a = 0; a < NUM_AREG; a++) m[a*PREG_W +: PREG_W] = mmap[a];
    return m;
  endfunction

  // Drive one cycle of inputs, advance the reference model and queue what must follow the edge.
  task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] h,
                      input areg_t a0, input preg_t p0, input areg_t a1, input preg_t p1,
                      input logic fl, input areg_t dbg);
    rec_t  r;
    areg_t a [2];
    preg_t p [2];
    a[0] = a0; a[1] = a1; p[0] = p0; p[1] = p1;
    reset = rst; commit_valid = v; commit_has_rd = h;
    commit_areg = {a1, a0}; commit_preg = {p1, p0}; flush = fl; dbg_areg = dbg;
    assert (int'(p0) < NUM_PREG && int'(p1) < NUM_PREG);
    r.fv = 2'b00;
    r.rv = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NUM_AREG; i++) mmap[i] = preg_t'(i);
      m_ret = 32'd0; m_fl = 16'd0; m_fp[0] = 7'd0; m_fp[1] = 7'd0;
    end else begin
      if (v == 2'b10) $display("WARNING protocol: slot1 valid while slot0 idle at %0t", $time);
      for (int i = 0; i < 2; i++) begin
        if (v[i] && h[i] && a[i] != 5'd0) begin
          r.fv[i] = 1'b1;
          m_fp[i] = mmap[a[i]];
          mmap[a[i]] = p[i];
          if (i == 0) fq0.push_back(m_fp[0]);
          else        fq1.push_back(m_fp[1]);
        end
      end
      m_ret = m_ret + 32'(v[0]) + 32'(v[1]);
      if (fl) begin
        m_fl = m_fl + 16'd1;
        r.rv = 1'b1;
        rq.push_back('{fl: m_fl, map: pack_map()});
      end
    end
    r.fp0 = m_fp[0]; r.fp1 = m_fp[1];
    r.ret = m_ret; r.fl = m_fl; r.map = pack_map();
    cq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input areg_t dbg);
    step(1'b1, 2'b00, 2'b00, 5'd0, 7'd0, 5'd0, 7'd0, 1'b0, dbg);
  endtask

  // Monitor: compares the DUT state after each edge against the record queued for that edge.
  always @(posedge clk) begin
    rec_t     r;
    rst_rec_t rr;
    preg_t    e;
    #3;
    if (cq.size() > 0) begin
      r = cq.pop_front();
      chk("freed_valid",   256'(freed_valid),   256'(r.fv));
      chk("freed_preg0",   256'(freed_preg[6:0]),  256'(r.fp0));
      chk("freed_preg1",   256'(freed_preg[13:7]), 256'(r.fp1));
      chk("restore_valid", 256'(restore_valid), 256'(r.rv));
      chk("retired_count", 256'(retired_count), 256'(r.ret));
      chk("flush_count",   256'(flush_count),   256'(r.fl));
      chk("map",           256'(restore_map),   256'(r.map));
      chk("dbg_preg",      256'(dbg_preg),      256'(r.map[int'(dbg_areg)*PREG_W +: PREG_W]));
      if (freed_valid[0]) begin
        if (fq0.size() == 0) chk("freed0_unexpected", 256'(1), 256'(0));
        else begin e = fq0.pop_front(); chk("freed0_tag", 256'(freed_preg[6:0]), 256'(e)); end
      end
      if (freed_valid[1]) begin
        if (fq1.size() == 0) chk("freed1_unexpected", 256'(1), 256'(0));
        else begin e = fq1.pop_front(); chk("freed1_tag", 256'(freed_preg[13:7]), 256'(e)); end
      end
      if (restore_valid) begin
        if (rq.size() == 0) chk("restore_unexpected", 256'(1), 256'(0));
        else begin
          rr = rq.pop_front();
          chk("restore_snapshot", 256'(restore_map), 256'(rr.map));
          chk("restore_flushcnt", 256'(flush_count), 256'(rr.fl));
        end
      end
    end
  end

  initial begin
    logic [1:0] v, h;
    areg_t      a0, a1;
    // reset and identity map readout
    step(1'b0, 2'b00, 2'b00, 5'd0, 7'd0, 5'd0, 7'd0, 1'b0, 5'd0);
    step(1'b0, 2'b00, 2'b00, 5'd0, 7'd0, 5'd0, 7'd0, 1'b0, 5'd0);
    for (int i = 0; i < NUM_AREG; i++) idle(areg_t'(i));
    // single commit x5->p40
    step(1'b1, 2'b01, 2'b01, 5'd5, 7'd40, 5'd0, 7'd0, 1'b0, 5'd5);
    idle(5'd5);
    // same areg in both slots
    step(1'b1, 2'b11, 2'b11, 5'd7, 7'd50, 5'd7, 7'd51, 1'b0, 5'd7);
    idle(5'd7);
    // x0 destination and has_rd=0 slot
    step(1'b1, 2'b11, 2'b01, 5'd0, 7'd60, 5'd3, 7'd99, 1'b0, 5'd3);
    idle(5'd0);
    // flush with same-cycle commit, then back-to-back flush with commit in restore cycle
    step(1'b1, 2'b01, 2'b01, 5'd9, 7'd70, 5'd0, 7'd0, 1'b1, 5'd9);
    step(1'b1, 2'b01, 2'b01, 5'd9, 7'd71, 5'd0, 7'd0, 1'b1, 5'd9);
    idle(5'd9);
    idle(5'd9);
    // slot1 only
    step(1'b1, 2'b10, 2'b10, 5'd0, 7'd0, 5'd12, 7'd33, 1'b0, 5'd12);
    idle(5'd12);
    // reset overrides a commit and flush
    step(1'b0, 2'b01, 2'b01, 5'd4, 7'd80, 5'd0, 7'd0, 1'b1, 5'd4);
    idle(5'd4);
    idle(5'd4);
    // randomized traffic, areg biased to a small set to provoke collisions
    for (int n = 0; n < 800; n++) begin
      v  = 2'($urandom_range(0, 3));
      h  = 2'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 1) == 0) ? areg_t'($urandom_range(0, 3)) : areg_t'($urandom);
      a1 = ($urandom_range(0, 1) == 0) ? a0 : areg_t'($urandom_range(0, 31));
      step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, v, h,
           a0, preg_t'($urandom), a1, preg_t'($urandom),
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, areg_t'($urandom));
    end
    idle(5'd0);
    idle(5'd0);
    #10;
    chk("cq_drain",  256'(cq.size()),  256'(0));
    chk("fq0_drain", 256'(fq0.size()), 256'(0));
    chk("fq1_drain", 256'(fq1.size()), 256'(0));
    chk("rq_drain",  256'(rq.size()),  256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
